coin_credit_accumulator: RTL and testbench

Parametrised successor to the vending-machine coin input counter. It keeps the customer's credit as a DIGITS-wide packed-BCD value and supports three operations. Coin insertion adds the coin's value. Vend subtracts a BCD price, but only if the credit covers it. Refund returns the whole credit and clears it. Add and subtract run digit-serially, one BCD digit per clock, and overflow or insufficient credit is reported instead of silently wrapping.

---
 rtl/vm_pkg.sv | 46 ++++
 rtl/coin_credit_accumulator_if.sv | 35 +++
 rtl/bcd_digit_addsub.sv | 34 +++
 rtl/coin_credit_accumulator.sv | 162 ++++++++++++++++
 tb/tb_coin_credit_accumulator.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// -----------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the coin credit accumulator:
//   - coin code constants (3-bit codes as presented on coin_code)
//   - FSM state encoding used by the top level
//   - coin_value_bcd(): maps a coin code to its packed-BCD value
// -----------------------------------------------------------------------------
package vm_pkg;

  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_5    = 3'd1;
  localparam logic [2:0] COIN_10   = 3'd2;
  localparam logic [2:0] COIN_20   = 3'd3;
  localparam logic [2:0] COIN_50   = 3'd4;
  localparam logic [2:0] COIN_100  = 3'd5;
  localparam logic [2:0] COIN_200  = 3'd6;
  localparam logic [2:0] COIN_500  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2
  } state_t;

  // Packed-BCD value of a coin, sized for the widest credit (8 digits).
  // Digits at or above 'digits' are forced to zero so a narrow credit never
  // sees a nonzero digit beyond its top.
  function automatic logic [31:0] coin_value_bcd(input logic [2:0] code, input int digits);
    logic [31:0] v;
    case (code)
      COIN_5:   v = 32'h0000_0005;
      COIN_10:  v = 32'h0000_0010;
      COIN_20:  v = 32'h0000_0020;
      COIN_50:  v = 32'h0000_0050;
      COIN_100: v = 32'h0000_0100;
      COIN_200: v = 32'h0000_0200;
      COIN_500: v = 32'h0000_0500;
      default:  v = 32'h0000_0000;
    endcase
    for (int i = 0; i < 8; i++) begin
      if (i >= digits) v[4*i +: 4] = 4'h0;
    end
    return v;
  endfunction

endpackage

// File: rtl/coin_credit_accumulator_if.sv
// -----------------------------------------------------------------------------
// coin_credit_accumulator_if
// Request/status bundle of the coin credit accumulator.
//   master : request source (drives *_valid, coin_code, price_bcd)
//   slave  : accumulator (drives ready, credit/refund values, status pulses)
// -----------------------------------------------------------------------------
interface coin_credit_accumulator_if #(
  parameter int DIGITS = 4
);
  logic                  ready;
  logic                  coin_valid;
  logic [2:0]            coin_code;
  logic                  vend_valid;
  logic [4*DIGITS-1:0]   price_bcd;
  logic                  refund_valid;
  logic [4*DIGITS-1:0]   credit_bcd;
  logic [4*DIGITS-1:0]   refund_bcd;
  logic                  coin_ok;
  logic                  coin_rej;
  logic                  vend_ok;
  logic                  vend_rej;
  logic                  refund_done;

  modport master (
    input  ready, credit_bcd, refund_bcd,
    input  coin_ok, coin_rej, vend_ok, vend_rej, refund_done,
    output coin_valid, coin_code, vend_valid, price_bcd, refund_valid
  );

  modport slave (
    output ready, credit_bcd, refund_bcd,
    output coin_ok, coin_rej, vend_ok, vend_rej, refund_done,
    input  coin_valid, coin_code, vend_valid, price_bcd, refund_valid
  );
endinterface

// File: rtl/bcd_digit_addsub.sv
// -----------------------------------------------------------------------------
// bcd_digit_addsub
// Combinational single-digit BCD adder/subtractor.
//   a, b : BCD digits       sub : 1 = a - b - cin, 0 = a + b + cin
//   cin  : carry/borrow in  y   : result digit      cout : carry/borrow out
// -----------------------------------------------------------------------------
module bcd_digit_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);
  logic [4:0] raw;

  always_comb begin
    raw  = '0;
    y    = '0;
    cout = 1'b0;
    if (sub) begin
      // Negative binary difference means a borrow; subtracting 6 mod 16
      // is the same as adding 10 to bring the digit back into 0..9.
      raw  = {1'b0, a} - {1'b0, b} - {4'b0, cin};
      cout = raw[4];
      y    = raw[4] ? raw[3:0] - 4'd6 : raw[3:0];
    end else begin
      // Sums above 9 skip the six unused codes and carry out.
      raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      cout = (raw > 5'd9);
      y    = cout ? raw[3:0] + 4'd6 : raw[3:0];
    end
  end
endmodule

// File: rtl/coin_credit_accumulator.sv
// -----------------------------------------------------------------------------
// coin_credit_accumulator
// Packed-BCD customer credit with coin add, checked vend subtract and refund.
// Add/subtract run one digit per clock through a shared bcd_digit_addsub.
//   clk     : system clock
//   clear_n : synchronous active-low reset
//   bus     : request/status bundle (slave side), see coin_credit_accumulator_if
// -----------------------------------------------------------------------------
module coin_credit_accumulator
  import vm_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        clear_n,
  coin_credit_accumulator_if.slave    bus
);
  localparam int W = 4 * DIGITS;

  state_t         state, state_nx;
  logic [W-1:0]   credit, refund, work, work_nx, operand;
  logic [3:0]     idx;
  logic           carry, bad, last;
  logic [3:0]     dig_a, dig_b, dig_y;
  logic           dig_cout;
  logic           coin_ok, coin_rej, vend_ok, vend_rej, refund_done;
  logic           coin_req;

  function automatic logic price_has_bad(input logic [W-1:0] p);
    logic any;
    any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (p[4*i +: 4] > 4'd9) any = 1'b1;
    end
    return any;
  endfunction

  assign coin_req = bus.coin_valid && (bus.coin_code != COIN_NONE);
  assign last     = (idx == 4'(DIGITS - 1));

  // Select the digit pair currently being processed.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) begin
        dig_a = work[4*i +: 4];
        dig_b = operand[4*i +: 4];
      end
    end
  end

  bcd_digit_addsub u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .sub  (state == SUB),
    .cin  (carry),
    .y    (dig_y),
    .cout (dig_cout)
  );

  // Working value with the current digit replaced; used for the final commit
  // so the last digit lands in credit on the same edge it is computed.
  always_comb begin
    work_nx = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) work_nx[4*i +: 4] = dig_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.refund_valid)    state_nx = IDLE;
        else if (bus.vend_valid) state_nx = SUB;
        else if (coin_req)       state_nx = ADD;
      end
      ADD, SUB: if (last) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      credit      <= '0;
      refund      <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      bad         <= 1'b0;
      coin_ok     <= 1'b0;
      coin_rej    <= 1'b0;
      vend_ok     <= 1'b0;
      vend_rej    <= 1'b0;
      refund_done <= 1'b0;
    end else begin
      coin_ok     <= 1'b0;
      coin_rej    <= 1'b0;
      vend_ok     <= 1'b0;
      vend_rej    <= 1'b0;
      refund_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.refund_valid) begin
            refund      <= credit;
            credit      <= '0;
            refund_done <= 1'b1;
          end else if (bus.vend_valid) begin
            operand <= bus.price_bcd;
            work    <= credit;
            idx     <= '0;
            carry   <= 1'b0;
            bad     <= price_has_bad(bus.price_bcd);
          end else if (coin_req) begin
            operand <= W'(coin_value_bcd(bus.coin_code, DIGITS));
            work    <= credit;
            idx     <= '0;
            carry   <= 1'b0;
            bad     <= 1'b0;
          end
        end
        ADD, SUB: begin
          work  <= work_nx;
          carry <= dig_cout;
          idx   <= idx + 4'd1;
          if (last) begin
            if (state == ADD) begin
              if (!dig_cout) begin
                credit  <= work_nx;
                coin_ok <= 1'b1;
              end else begin
                coin_rej <= 1'b1;
              end
            end else begin
              if (!dig_cout && !bad) begin
                credit  <= work_nx;
                vend_ok <= 1'b1;
              end else begin
                vend_rej <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = (state == IDLE) && clear_n;
  assign bus.credit_bcd  = credit;
  assign bus.refund_bcd  = refund;
  assign bus.coin_ok     = coin_ok;
  assign bus.coin_rej    = coin_rej;
  assign bus.vend_ok     = vend_ok;
  assign bus.vend_rej    = vend_rej;
  assign bus.refund_done = refund_done;
endmodule

// File: tb/tb_coin_credit_accumulator.sv
// -----------------------------------------------------------------------------
// tb_coin_credit_accumulator
// Self-checking bench: directed scenarios plus randomized requests compared
// against a decimal-integer model of the credit.
// -----------------------------------------------------------------------------
module tb_coin_credit_accumulator;
  import vm_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 10 ** DIGITS - 1;

  localparam logic [4:0] S_NONE     = 5'b00000;
  localparam logic [4:0] S_COIN_OK  = 5'b10000;
  localparam logic [4:0] S_COIN_REJ = 5'b01000;
  localparam logic [4:0] S_VEND_OK  = 5'b00100;
  localparam logic [4:0] S_VEND_REJ = 5'b00010;
  localparam logic [4:0] S_REFUND   = 5'b00001;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;

  coin_credit_accumulator_if #(.DIGITS(DIGITS)) bus ();

  coin_credit_accumulator #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int credit_m = 0;
  int refund_m = 0;
  int coin_ok_cnt  = 0;
  int coin_rej_cnt = 0;

  always @(negedge clk) begin
    if (bus.coin_ok)  coin_ok_cnt++;
    if (bus.coin_rej) coin_rej_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic int coin_amount(input logic [2:0] c);
    int vals [8] = '{0, 5, 10, 20, 50, 100, 200, 500};
    return vals[c];
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal value of a BCD word, or -1 when any digit is not a decimal digit.
  function automatic int bcd_value(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return -1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic logic [4:0] status();
    return {bus.coin_ok, bus.coin_rej, bus.vend_ok, bus.vend_rej, bus.refund_done};
  endfunction

  task automatic request(input bit rf, input bit vd, input bit cn,
                         input logic [2:0] code, input logic [W-1:0] price);
    int waited, busy, glitch, pv, credit_before;
    logic [4:0] exp_st;
    bit multi;
    @(negedge clk);
    waited = 0;
    while (!bus.ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready) begin
      check("ready_timeout", 32'(bus.ready), 32'd1);
      return;
    end
    bus.refund_valid = rf;
    bus.vend_valid   = vd;
    bus.coin_valid   = cn;
    bus.coin_code    = code;
    bus.price_bcd    = price;
    @(posedge clk);
    #1;
    bus.refund_valid = 1'b0;
    bus.vend_valid   = 1'b0;
    bus.coin_valid   = 1'b0;

    credit_before = credit_m;
    multi  = 1'b0;
    exp_st = S_NONE;
    if (rf) begin
      refund_m = credit_m;
      credit_m = 0;
      exp_st   = S_REFUND;
    end else if (vd) begin
      multi = 1'b1;
      pv = bcd_value(price);
      if (pv < 0 || pv > credit_m) exp_st = S_VEND_REJ;
      else begin
        credit_m -= pv;
        exp_st = S_VEND_OK;
      end
    end else if (cn && code != COIN_NONE) begin
      multi = 1'b1;
      if (credit_m + coin_amount(code) > MAXV) exp_st = S_COIN_REJ;
      else begin
        credit_m += coin_amount(code);
        exp_st = S_COIN_OK;
      end
    end

    if (multi) begin
      busy   = 0;
      glitch = 0;
      for (int k = 0; k < DIGITS; k++) begin
        if (!bus.ready) busy++;
        if (bus.credit_bcd !== to_bcd(credit_before) || status() !== S_NONE) glitch++;
        @(posedge clk);
        #1;
      end
      check("busy_cycles", 32'(busy), 32'(DIGITS));
      check("no_partial", 32'(glitch), 32'd0);
    end
    check("status", 32'(status()), 32'(exp_st));
    check("credit", 32'(bus.credit_bcd), 32'(to_bcd(credit_m)));
    check("refund_bcd", 32'(bus.refund_bcd), 32'(to_bcd(refund_m)));
    check("ready_after", 32'(bus.ready), 32'd1);
    if (exp_st != S_NONE) begin
      @(posedge clk);
      #1;
      check("pulse_width", 32'(status()), 32'(S_NONE));
    end
  endtask

  task automatic coin(input logic [2:0] code);
    request(1'b0, 1'b0, 1'b1, code, '0);
  endtask

  task automatic vend(input logic [W-1:0] price);
    request(1'b0, 1'b1, 1'b0, COIN_NONE, price);
  endtask

  task automatic refund();
    request(1'b1, 1'b0, 1'b0, COIN_NONE, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ok0, rej0;
    logic [W-1:0] p;
    bus.coin_valid   = 1'b0;
    bus.coin_code    = COIN_NONE;
    bus.vend_valid   = 1'b0;
    bus.price_bcd    = '0;
    bus.refund_valid = 1'b0;

    // Power-up reset
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_credit", 32'(bus.credit_bcd), 32'h0);
    check("rst_refund", 32'(bus.refund_bcd), 32'h0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_status", 32'(status()), 32'(S_NONE));
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    check("rst_ready_release", 32'(bus.ready), 32'd1);

    // 201 five-unit coins
    coin_ok_cnt = 0;
    for (int i = 0; i < 201; i++) coin(COIN_5);
    check("coin5_total", 32'(bus.credit_bcd), 32'h1005);
    check("coin5_ok_count", 32'(coin_ok_cnt), 32'd201);

    // Build 9990, then overflow
    refund();
    check("refund_1005", 32'(bus.refund_bcd), 32'h1005);
    for (int i = 0; i < 19; i++) coin(COIN_500);
    coin(COIN_200);
    coin(COIN_200);
    coin(COIN_50);
    coin(COIN_20);
    coin(COIN_20);
    check("credit_9990", 32'(bus.credit_bcd), 32'h9990);
    coin(COIN_50);
    check("ovf_credit_kept", 32'(bus.credit_bcd), 32'h9990);
    coin(COIN_NONE);
    check("coin0_credit", 32'(bus.credit_bcd), 32'h9990);
    coin(COIN_5);
    coin(COIN_5);
    check("ovf_9995", 32'(bus.credit_bcd), 32'h9995);

    // Vend cases
    refund();
    coin(COIN_20);
    vend(16'h0015);
    check("vend_0005", 32'(bus.credit_bcd), 32'h0005);
    vend(16'h0025);
    check("vend_short", 32'(bus.credit_bcd), 32'h0005);
    vend(16'h00A0);
    check("vend_bad_digit", 32'(bus.credit_bcd), 32'h0005);
    vend(16'h0005);
    check("vend_exact", 32'(bus.credit_bcd), 32'h0000);

    // Priority: refund wins over vend and coin
    coin(COIN_200);
    coin(COIN_100);
    coin(COIN_50);
    request(1'b1, 1'b1, 1'b1, COIN_100, 16'h0100);
    check("prio_refund", 32'(bus.refund_bcd), 32'h0350);
    check("prio_credit", 32'(bus.credit_bcd), 32'h0000);
    vend(16'h0100);
    vend(16'h0000);

    // Reset in the middle of an add
    coin(COIN_100);
    check("mid_pre", 32'(bus.credit_bcd), 32'h0100);
    ok0  = coin_ok_cnt;
    rej0 = coin_rej_cnt;
    @(negedge clk);
    bus.coin_valid = 1'b1;
    bus.coin_code  = COIN_500;
    @(posedge clk);
    #1;
    bus.coin_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_credit", 32'(bus.credit_bcd), 32'h0000);
    check("mid_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    repeat (DIGITS + 1) @(negedge clk);
    check("mid_no_pulse", 32'((coin_ok_cnt - ok0) + (coin_rej_cnt - rej0)), 32'd0);
    check("mid_ready_back", 32'(bus.ready), 32'd1);
    check("mid_credit_after", 32'(bus.credit_bcd), 32'h0000);
    credit_m = 0;
    refund_m = 0;

    // Randomized mix
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       p = to_bcd(int'($urandom_range(0, credit_m)));
        1:       p = to_bcd(int'($urandom_range(0, MAXV)));
        2:       p = W'($urandom);
        default: p = to_bcd(credit_m);
      endcase
      request($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, 3'($urandom), p);
    end

    // Reset after arbitrary activity
    @(negedge clk);
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_credit", 32'(bus.credit_bcd), 32'h0);
    check("rst2_refund", 32'(bus.refund_bcd), 32'h0);
    check("rst2_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    check("rst2_ready_release", 32'(bus.ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
